// File: rtl/ghash_tag_verify_if.sv
// ghash_tag_verify_if
//   Beat stream into the GHASH tag checker. The master presents 128-bit
//   GHASH input blocks and the received tag; the slave returns o_ready.
//   Signals:
//     i_valid  beat valid (master -> slave)
//     o_ready  slave can absorb a beat (slave -> master)
//     i_data   GHASH input block, [0:127], bit 0 = GCM MSB
//     i_last   beat is the len(A)||len(C) block
//     i_tag    received tag, meaningful on the i_last beat
interface ghash_tag_verify_if;
  logic         i_valid;
  logic         o_ready;
  logic [0:127] i_data;
  logic         i_last;
  logic [0:127] i_tag;

  modport master (output i_valid, i_data, i_last, i_tag, input o_ready);
  modport slave  (input i_valid, i_data, i_last, i_tag, output o_ready);
endinterface

// File: rtl/ghash_tag_verify.sv
// ghash_tag_verify
//   Receive-side GCM tag check. Absorbs GHASH input blocks (AAD, ciphertext,
//   length block) through a bit-serial GF(2^128) multiply (128 cycles per
//   block), then forms tag = GHASH ^ E_K(J0) and compares it with the
//   received tag.
//   Ports:
//     clk, reset   clock; synchronous active-high reset
//     i_start      begin a message; loads i_h / i_ekj0, aborts any multiply
//     i_h          hash subkey H
//     i_ekj0       E_K(J0)
//     bus          beat stream (slave side): i_valid/o_ready/i_data/i_last/i_tag
//     o_done       one-cycle verdict pulse
//     o_pass       computed tag matched received tag
//     o_tag        computed tag
//   All 128-bit vectors are [0:127] with bit 0 the GCM MSB.
module ghash_tag_verify (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic [0:127]        i_h,
  input  logic [0:127]        i_ekj0,
  ghash_tag_verify_if.slave   bus,
  output logic                o_done,
  output logic                o_pass,
  output logic [0:127]        o_tag
);

  // Reduction constant 0xE1 || 0^120 in GCM bit order.
  localparam logic [0:127] R_POLY = {8'hE1, 120'h0};

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_MULT, ST_FINAL} state_t;

  state_t       state_q, state_d;
  logic [0:127] h_q, h_d, ekj0_q, ekj0_d, tag_r_q, tag_r_d;
  logic [0:127] y_q, y_d, z_q, z_d, v_q, v_d, x_q, x_d;
  logic [6:0]   cnt_q, cnt_d;
  logic         last_q, last_d;
  logic         done_q, done_d, pass_q, pass_d;
  logic [0:127] otag_q, otag_d;

  logic [0:127] z_step, v_step, tag_calc;

  // One iteration of SP 800-38D Alg. 1 for the bit currently scanned.
  assign z_step   = x_q[cnt_q] ? (z_q ^ v_q) : z_q;
  assign v_step   = v_q[127] ? ((v_q >> 1) ^ R_POLY) : (v_q >> 1);
  assign tag_calc = y_q ^ ekj0_q;

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    ekj0_d  = ekj0_q;
    tag_r_d = tag_r_q;
    y_d     = y_q;
    z_d     = z_q;
    v_d     = v_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    otag_d  = otag_q;

    if (i_start) begin
      // Start wins over everything: a beat in the same cycle is dropped
      // and any in-flight multiply is abandoned.
      h_d     = i_h;
      ekj0_d  = i_ekj0;
      y_d     = '0;
      last_d  = 1'b0;
      pass_d  = 1'b0;
      otag_d  = '0;
      state_d = ST_WAIT;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_WAIT: begin
          if (bus.i_valid) begin
            x_d     = y_q ^ bus.i_data;
            z_d     = '0;
            v_d     = h_q;
            cnt_d   = 7'd0;
            last_d  = bus.i_last;
            if (bus.i_last) tag_r_d = bus.i_tag;
            state_d = ST_MULT;
          end
        end
        ST_MULT: begin
          z_d   = z_step;
          v_d   = v_step;
          cnt_d = cnt_q + 7'd1;
          if (cnt_q == 7'd127) begin
            y_d     = z_step;
            state_d = last_q ? ST_FINAL : ST_WAIT;
          end
        end
        ST_FINAL: begin
          otag_d  = tag_calc;
          pass_d  = (tag_calc == tag_r_q);
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      ekj0_q  <= '0;
      tag_r_q <= '0;
      y_q     <= '0;
      z_q     <= '0;
      v_q     <= '0;
      x_q     <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      otag_q  <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      ekj0_q  <= ekj0_d;
      tag_r_q <= tag_r_d;
      y_q     <= y_d;
      z_q     <= z_d;
      v_q     <= v_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      otag_q  <= otag_d;
    end
  end

  // Ready decodes straight from the state register, so no input reaches it.
  assign bus.o_ready = (state_q == ST_WAIT);
  assign o_done      = done_q;
  assign o_pass      = pass_q;
  assign o_tag       = otag_q;

endmodule

// File: tb/tb_ghash_tag_verify.sv
// Directed bench for ghash_tag_verify using NIST GCM test cases 1 and 2.
module tb_ghash_tag_verify;
  logic         clk = 1'b0;
  logic         reset;
  logic         i_start;
  logic [0:127] i_h, i_ekj0;
  logic         o_done, o_pass;
  logic [0:127] o_tag;

  ghash_tag_verify_if bus ();

  ghash_tag_verify dut (
    .clk     (clk),
    .reset   (reset),
    .i_start (i_start),
    .i_h     (i_h),
    .i_ekj0  (i_ekj0),
    .bus     (bus),
    .o_done  (o_done),
    .o_pass  (o_pass),
    .o_tag   (o_tag)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] H_K0   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] EKJ0_0 = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [127:0] C2     = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] LEN2   = 128'h00000000000000000000000000000080;
  localparam logic [127:0] TAG2   = 128'hab6e47d42cec13bdf53a67b21257bddf;
  localparam logic [127:0] TAG2X  = 128'hab6e47d42cec13bdf53a67b21257bdde;
  localparam logic [127:0] H_ARB  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] X_ONE  = 128'h80000000000000000000000000000000;

  int nchk = 0;
  int nerr = 0;
  int ndone = 0;
  int done_run = 0;
  logic done_prev = 1'b0;

  // Pulse counting and the never-two-cycles property are watched continuously.
  always @(negedge clk) begin
    if (o_done) ndone <= ndone + 1;
    if (o_done && done_prev) done_run <= done_run + 1;
    done_prev <= o_done;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: pulse i_start for one edge, then check o_ready at S+1.
  task automatic do_start(input logic [127:0] h, input logic [127:0] e);
    i_start = 1'b1; i_h = h; i_ekj0 = e;
    @(negedge clk);
    i_start = 1'b0;
    chk("ready_after_start", 128'(bus.o_ready), 128'd1);
  endtask

  // Called at a negedge: present a beat, wait for ready, return at cycle T+1.
  task automatic hs(input logic [127:0] d, input logic last, input logic [127:0] t);
    bus.i_valid = 1'b1; bus.i_data = d; bus.i_last = last; bus.i_tag = t;
    for (int k = 0; k < 300 && !bus.o_ready; k++) @(negedge clk);
    if (!bus.o_ready) chk("hs_timeout", 128'(bus.o_ready), 128'd1);
    @(negedge clk);
    bus.i_valid = 1'b0;
  endtask

  // From cycle T+1 to T+129: o_ready low for exactly 128 cycles. With abuse,
  // i_valid is held high and i_data scrambled while the multiply runs.
  task automatic wait_mult(input bit abuse, input logic last);
    int low = 0;
    int d0 = ndone;
    for (int j = 1; j <= 128; j++) begin
      if (!bus.o_ready) low++;
      if (abuse) begin
        bus.i_valid = (j < 128);
        bus.i_data  = {$urandom, $urandom, $urandom, $urandom};
        bus.i_last  = j[0];
      end
      @(negedge clk);
    end
    bus.i_valid = 1'b0;
    chk("ready_low_128", 128'(low), 128'd128);
    chk("no_done_in_mult", 128'(ndone - d0), 128'd0);
    chk("ready_at_T129", 128'(bus.o_ready), last ? 128'd0 : 128'd1);
  endtask

  // From cycle T+129 (FINAL): verdict at T+130, gone at T+131, tag held.
  task automatic final_check(input string nm, input logic [127:0] et, input logic ep);
    chk({nm, "_done_T129"}, 128'(o_done), 128'd0);
    @(negedge clk);
    chk({nm, "_done_T130"}, 128'(o_done), 128'd1);
    chk({nm, "_tag"}, o_tag, et);
    chk({nm, "_pass"}, 128'(o_pass), 128'(ep));
    @(negedge clk);
    chk({nm, "_done_T131"}, 128'(o_done), 128'd0);
    chk({nm, "_tag_hold"}, o_tag, et);
    chk({nm, "_ready_idle"}, 128'(bus.o_ready), 128'd0);
  endtask

  initial begin
    int d0;
    reset = 1'b1; i_start = 1'b0; i_h = '0; i_ekj0 = '0;
    bus.i_valid = 1'b0; bus.i_data = '0; bus.i_last = 1'b0; bus.i_tag = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 128'(bus.o_ready), 128'd0);
    chk("rst_done", 128'(o_done), 128'd0);
    chk("rst_pass", 128'(o_pass), 128'd0);
    chk("rst_tag", o_tag, 128'd0);
    reset = 1'b0;

    // Beats offered in IDLE before any start are not taken.
    bus.i_valid = 1'b1; bus.i_data = C2; bus.i_last = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_ready", 128'(bus.o_ready), 128'd0);
    bus.i_valid = 1'b0;

    // TC1: empty message.
    do_start(H_K0, EKJ0_0);
    hs(128'd0, 1'b1, EKJ0_0);
    wait_mult(1'b0, 1'b1);
    final_check("tc1", EKJ0_0, 1'b1);

    // TC2 with handshake abuse; start clears the previous verdict.
    do_start(H_K0, EKJ0_0);
    chk("start_clr_tag", o_tag, 128'd0);
    chk("start_clr_pass", 128'(o_pass), 128'd0);
    // A beat concurrent with i_start in WAIT must be dropped.
    i_start = 1'b1; bus.i_valid = 1'b1; bus.i_data = 128'hdead; bus.i_last = 1'b1;
    @(negedge clk);
    i_start = 1'b0; bus.i_valid = 1'b0;
    chk("start_beats_valid", 128'(bus.o_ready), 128'd1);
    hs(C2, 1'b0, 128'd0);
    wait_mult(1'b1, 1'b0);
    hs(LEN2, 1'b1, TAG2);
    wait_mult(1'b1, 1'b1);
    final_check("tc2", TAG2, 1'b1);

    // TC2 with received-tag bit 127 flipped.
    do_start(H_K0, EKJ0_0);
    hs(C2, 1'b0, 128'd0);
    wait_mult(1'b0, 1'b0);
    hs(LEN2, 1'b1, TAG2X);
    wait_mult(1'b0, 1'b1);
    final_check("tc2bad", TAG2, 1'b0);

    // Multiplying by the GF identity returns H.
    do_start(H_ARB, 128'd0);
    hs(X_ONE, 1'b1, H_ARB);
    wait_mult(1'b0, 1'b1);
    final_check("ident", H_ARB, 1'b1);

    // Abort a TC2 multiply at iteration 60 with a fresh start, then run TC1.
    d0 = ndone;
    do_start(H_K0, EKJ0_0);
    hs(C2, 1'b0, 128'd0);
    repeat (60) @(negedge clk);
    do_start(H_K0, EKJ0_0);
    hs(128'd0, 1'b1, EKJ0_0);
    wait_mult(1'b0, 1'b1);
    chk("abort_no_done", 128'(ndone - d0), 128'd0);
    final_check("abort_tc1", EKJ0_0, 1'b1);

    // Reset in the middle of a multiply.
    do_start(H_K0, EKJ0_0);
    hs(LEN2, 1'b1, TAG2);
    repeat (30) @(negedge clk);
    d0 = ndone;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_ready", 128'(bus.o_ready), 128'd0);
    chk("midrst_done", 128'(o_done), 128'd0);
    chk("midrst_tag", o_tag, 128'd0);
    chk("midrst_pass", 128'(o_pass), 128'd0);
    repeat (140) @(negedge clk);
    chk("midrst_no_done", 128'(ndone - d0), 128'd0);
    chk("done_single_cycle", 128'(done_run), 128'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
